// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared types, constants and the round-robin winner search for decoder_rr_arbiter.
package decoder_rr_arbiter_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } win_t;

    // First set bit of req, scanning upward from start+1 and wrapping; start is scanned last.
    function automatic win_t find_winner(input logic [N_REQ-1:0] req,
                                         input logic [IDX_W-1:0] start);
        win_t             res;
        logic [IDX_W-1:0] k;
        res = '0;
        k   = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            k = start + IDX_W'(i);
            if (!res.found && req[k]) begin
                res.found = 1'b1;
                res.idx   = k;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface decoder_rr_arbiter_if
    import decoder_rr_arbiter_pkg::*;
();
    logic             i_en;
    logic [N_REQ-1:0] i_req;
    logic [N_REQ-1:0] o_gnt;
    logic [IDX_W-1:0] o_gnt_idx;
    logic             o_gnt_vld;
    logic             o_forced;

    modport master (
        output i_en,
        output i_req,
        input  o_gnt,
        input  o_gnt_idx,
        input  o_gnt_vld,
        input  o_forced
    );

    modport slave (
        input  i_en,
        input  i_req,
        output o_gnt,
        output o_gnt_idx,
        output o_gnt_vld,
        output o_forced
    );
endinterface

// File: rtl/decoder_rr_arbiter_dec.sv
// Plain 2-to-4 one-hot decoder with enable.
module decoder_2_to_4 (
    input  logic       i_en,
    input  logic [1:0] i_addr,
    output logic [3:0] o_y
);

    // One-hot decode of the address, all zero when disabled.
    always_comb begin
        o_y = 4'b0000;
        if (i_en) begin
            case (i_addr)
                2'd0:    o_y = 4'b0001;
                2'd1:    o_y = 4'b0010;
                2'd2:    o_y = 4'b0100;
                default: o_y = 4'b1000;
            endcase
        end
    end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Four-way round-robin arbiter with bounded hold time; one-hot grant decoded from registers.
module decoder_rr_arbiter
    import decoder_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    decoder_rr_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] last_owner_q, last_owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             forced_q, forced_d;

    logic [N_REQ-1:0] own_bit;
    logic [N_REQ-1:0] others_req;
    win_t             win_all;
    win_t             win_oth;
    logic             gnt_vld;
    logic [N_REQ-1:0] gnt_onehot;

    // Requests from everyone except the current owner, for forced handover.
    always_comb begin
        own_bit            = '0;
        own_bit[gnt_idx_q] = 1'b1;
        others_req         = bus.i_req & ~own_bit;
        win_all            = find_winner(bus.i_req, last_owner_q);
        win_oth            = find_winner(others_req, last_owner_q);
    end

    // Next-state and next-register logic of the arbitration FSM.
    always_comb begin
        state_d      = state_q;
        gnt_idx_d    = gnt_idx_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        forced_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_en && win_all.found) begin
                    state_d      = ST_GRANT;
                    gnt_idx_d    = win_all.idx;
                    last_owner_d = win_all.idx;
                    cnt_d        = CNT_W'(1);
                end
            end

            ST_GRANT: begin
                if (!bus.i_en) begin
                    state_d   = ST_IDLE;
                    gnt_idx_d = '0;
                    cnt_d     = '0;
                end else if (!bus.i_req[gnt_idx_q]) begin
                    // Owner released: hand over in the same edge, or go idle.
                    if (win_all.found) begin
                        gnt_idx_d    = win_all.idx;
                        last_owner_d = win_all.idx;
                        cnt_d        = CNT_W'(1);
                    end else begin
                        state_d   = ST_IDLE;
                        gnt_idx_d = '0;
                        cnt_d     = '0;
                    end
                end else if ((cnt_q == CNT_W'(MAX_HOLD)) && win_oth.found) begin
                    gnt_idx_d    = win_oth.idx;
                    last_owner_d = win_oth.idx;
                    cnt_d        = CNT_W'(1);
                    forced_d     = 1'b1;
                end else if (cnt_q != CNT_W'(MAX_HOLD)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d   = ST_IDLE;
                gnt_idx_d = '0;
                cnt_d     = '0;
            end
        endcase
    end

    // State and grant registers with synchronous reset; pointer resets to 3 so requester 0 leads.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            gnt_idx_q    <= '0;
            last_owner_q <= IDX_W'(N_REQ - 1);
            cnt_q        <= '0;
            forced_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_idx_q    <= gnt_idx_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            forced_q     <= forced_d;
        end
    end

    assign gnt_vld = (state_q == ST_GRANT);

    decoder_2_to_4 u_dec (
        .i_en   (gnt_vld),
        .i_addr (gnt_idx_q),
        .o_y    (gnt_onehot)
    );

    assign bus.o_gnt     = gnt_onehot;
    assign bus.o_gnt_idx = gnt_idx_q;
    assign bus.o_gnt_vld = gnt_vld;
    assign bus.o_forced  = forced_q;

endmodule

// File: doc/decoder_rr_arbiter.md
Name: decoder_rr_arbiter

Overview:
- Four-requester round-robin arbiter that shares one resource. The one-hot select that enables a requester's path comes from a 2-to-4 decoder.
- Holds the granted index in registers and drives the decoder's enable and address from them.
- Produces a registered one-hot grant with a bounded hold time.
- Sits in front of any shared 4-way resource (bus, memory port, mux select) in the datapath.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles for one owner while others wait; legal range 1..255.
- CNT_W, $clog2(MAX_HOLD+1), hold-counter width; derived, not overridden.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_en  input  1  arbitration enable; low forces release and blocks new grants.
- i_req  input  4  request vector, bit k = requester k.
- o_gnt  output  4  one-hot grant; all zero when no grant.
- o_gnt_idx  output  2  encoded index of current owner; valid only when o_gnt_vld=1.
- o_gnt_vld  output  1  high while a grant is held.
- o_forced  output  1  one-cycle pulse on the cycle after a MAX_HOLD forced handover.

Behaviour:
- Reset (i_rst=1 at edge), next cycle:
  - State=IDLE, o_gnt_vld=0, o_gnt=0000, o_gnt_idx=00, o_forced=0, hold count=0.
  - Priority pointer last_owner=3, so requester 0 has top priority first.
- Reset mid-grant: grant drops on the next edge with no completion.
- o_gnt is the decoder output, with enable=o_gnt_vld and address=o_gnt_idx.
  - It is purely a function of registers, so there is no combinational path from i_req to o_gnt.
- Winner search: scan i_req from (last_owner+1) mod 4, wrapping upward. The first set bit wins. last_owner is scanned last.
- State machine, IDLE:
  - If i_en=1 and i_req!=0: go to GRANT. o_gnt_idx=winner, o_gnt_vld=1, count=1, last_owner=winner.
  - Otherwise stay in IDLE.
- Latency: one request-to-grant cycle (request sampled at edge N, o_gnt valid after edge N).
- State machine, GRANT with owner k; evaluate in this order at each edge:
  1. i_en=0: go to IDLE, grant cleared, last_owner kept.
  2. i_req[k]=0 (release): run the winner search over the current i_req.
     - If any bit is set: new GRANT, count=1, no idle gap.
     - If none: go to IDLE.
  3. count==MAX_HOLD and any other bit of i_req set: forced handover to the search winner (k is excluded, being scanned last), count=1, o_forced=1 next cycle.
  4. Otherwise stay: count increments, saturating at MAX_HOLD.
- Sole requester exceeding MAX_HOLD: keeps the grant indefinitely, no o_forced.
- Simultaneous release and new requests: handled in the same edge by rule 2.
- The pointer always updates to the new owner on every grant, giving fairness.
- MAX_HOLD=1: handover on every cycle while multiple requests are pending (strict rotation).
- o_forced is high for exactly one cycle and is otherwise 0.

Decomposition:
- Shared package:
  - State enum (IDLE, GRANT).
  - Requester count constant (4) and index width (2).
  - Winner-search function: find the first set bit of a 4-bit vector starting from a given offset.
- Sub-module: instantiate the existing decoder_2_to_4 for the one-hot output.
- No other sub-modules.

Test Plan:
- Reset, then i_en=1, i_req=0001:
  - After 1 edge, o_gnt=0001, o_gnt_idx=00, o_gnt_vld=1.
  - Drop i_req: after 1 edge, o_gnt=0000, o_gnt_vld=0.
- Rotation: i_req=1111 held, each owner dropping its bit for one cycle after 1 grant cycle:
  - Grant sequence is 0001, 0010, 0100, 1000, 0001, with no idle cycles between grants.
- Forced handover, MAX_HOLD=8: owner 0 holds with i_req=0101:
  - o_gnt=0001 for exactly 8 cycles, then o_gnt=0100 and o_forced=1 for one cycle.
  - With i_req=0001 only, the grant holds for 20+ cycles with o_forced=0.
- Enable gating: while granted to 2, set i_en=0:
  - Next cycle o_gnt=0000.
  - i_en=1 with i_req=0111: grant goes to 0 (pointer kept at 2, so scan starts at 3, wraps to 0).
- Reset mid-grant: while granted to 3, assert i_rst for one cycle with i_req=1111:
  - Outputs go to 0 on the next edge.
  - After release of reset, first grant goes to 0.
- Simultaneous release and wrap: owner 3 drops its request on the same edge requester 1 raises:
  - Next cycle o_gnt=0010, o_gnt_idx=01.
